// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider sequencer.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_iter_unit.sv
// One combinational restoring-division step: shift {A,Q} left, trial-subtract M.
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] a_sh;
    logic           fits;

    always_comb begin
        a_sh = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
        fits = (a_sh >= {1'b0, m_i});
        a_o  = fits ? (a_sh - {1'b0, m_i}) : a_sh;
        q_o  = {q_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Start/busy/done sequencer for signed/unsigned restoring division (quotient->lo, remainder->hi).
// Optional DIV_EARLY_EXIT_EN skips the leading-zero iterations of |dividend|.
//
//  state | meaning
//  IDLE  | waiting for start; operands captured on start
//  PREP  | divide-by-zero check, magnitudes, sign flags, iteration count
//  ITER  | one restoring step per cycle
//  FIXUP | apply quotient/remainder signs
//  DONE  | publish results; done pulses on the following cycle
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_zero
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d, step_a;
    logic [WIDTH-1:0] q_q, q_d, m_q, m_d, step_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
    logic             publish;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic             done_q, dzo_q;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] abs_dvd, abs_dvs;

`ifdef DIV_EARLY_EXIT_EN
    function automatic logic [CNT_W-1:0] clz(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 1'b1;
            end
        end
        return n;
    endfunction
`endif

    div_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    always_comb begin
        dvd_neg = sgn_q & q_q[WIDTH-1];
        dvs_neg = sgn_q & m_q[WIDTH-1];
        abs_dvd = dvd_neg ? -q_q : q_q;
        abs_dvs = dvs_neg ? -m_q : m_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = PREP;
            PREP: begin
                if (m_q == '0) begin
                    state_d = DONE;
                end else begin
`ifdef DIV_EARLY_EXIT_EN
                    state_d = (abs_dvd == '0) ? FIXUP : ITER;
`else
                    state_d = ITER;
`endif
                end
            end
            ITER:  if (cnt_q == CNT_W'(1)) state_d = FIXUP;
            FIXUP: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        publish = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    m_d   = divisor;
                    sgn_d = signed_op;
                end
            end
            PREP: begin
                if (m_q == '0) begin
                    // Raw dividend goes to hi untouched, quotient saturates.
                    a_d  = {1'b0, q_q};
                    q_d  = DIV_ZERO_Q;
                    dz_d = 1'b1;
                end else begin
                    a_d     = '0;
                    m_d     = abs_dvs;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    dz_d    = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
                    q_d   = abs_dvd << clz(abs_dvd);
                    cnt_d = CNT_W'(WIDTH) - clz(abs_dvd);
`else
                    q_d   = abs_dvd;
                    cnt_d = CNT_W'(WIDTH);
`endif
                end
            end
            ITER: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q - 1'b1;
            end
            FIXUP: begin
                q_d = q_neg_q ? -q_q : q_q;
                a_d = {1'b0, (r_neg_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0])};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs change only together with done so hi/lo/div_zero hold between operations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_q   <= '0;
            hi_q   <= '0;
            dzo_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= publish;
            if (publish) begin
                lo_q  <= q_q;
                hi_q  <= a_q[WIDTH-1:0];
                dzo_q <= dz_q;
            end
        end
    end

    assign done     = done_q;
    assign lo       = lo_q;
    assign hi       = hi_q;
    assign div_zero = dzo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (honours DIV_EARLY_EXIT_EN for latency).
module tb_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    div_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .lo        (lo),
        .hi        (hi),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Edges after the start edge until done is seen.
    function automatic int exp_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int          lz;
        if (b == 32'd0) return 2;
        mag = (sg && a[31]) ? -a : a;
        lz  = 0;
`ifdef DIV_EARLY_EXIT_EN
        if (mag == 32'd0) return 3;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) break;
            lz++;
        end
`endif
        return 32 - lz + 3;
    endfunction

    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                           input logic edz, input int pulse_at);
        int lat;
        int busy_low;
        lat      = 0;
        busy_low = 0;
        @(negedge clk);
        signed_op = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!done && lat < 200) begin
            if (!busy) busy_low++;
            if (lat == pulse_at) begin
                start     = 1'b1;
                signed_op = ~sg;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, exp_lat(sg, a, b));
        check({tag, " busy_window"}, busy_low, 0);
        check({tag, " lo"}, lo, elo);
        check({tag, " hi"}, hi, ehi);
        check({tag, " div_zero"}, div_zero, edz);
        check({tag, " busy_at_done"}, busy, 0);
    endtask

    initial begin
        int dones;
        reset     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst lo", lo, 0);
        check("rst hi", hi, 0);
        check("rst dz", div_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        run_div("u100/7",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, -1);
        run_div("s-100/7",  1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, -1);
        run_div("s100/-7",  1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, -1);
        run_div("u5/0",     1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, -1);
        run_div("u9/3",     1'b0, 32'd9,        32'd3,        32'd3,        32'd0,        1'b0, -1);
        run_div("s-5/0",    1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, -1);
        run_div("sMIN/-1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, -1);
        run_div("uMIN/max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, -1);
        run_div("u0/7",     1'b0, 32'd0,        32'd7,        32'd0,        32'd0,        1'b0, -1);
        run_div("s-7/2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, -1);
        run_div("ignore",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 4);

        // Abandon an operation with reset during ITER.
        @(negedge clk);
        signed_op = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst lo", lo, 0);
        check("midrst hi", hi, 0);
        check("midrst dz", div_zero, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("midrst no_done", dones, 0);

        run_div("u100/7b",  1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
